// File: rtl/viterbi_decoder_param.sv
// Hard-decision rate-1/2 Viterbi decoder with register-exchange survivors.
// Constraint length, generators, survivor depth and metric width are compile-time parameters.
module viterbi_decoder_param #(
   parameter int unsigned K        = 3,
   parameter int unsigned G0       = 7,
   parameter int unsigned G1       = 5,
   parameter int unsigned TB_DEPTH = 15,
   parameter int unsigned METRIC_W = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       restart,
   input  logic       in_valid,
   input  logic [1:0] in_bits,
   output logic       out_valid,
   output logic       out_bit
);
   localparam int unsigned N  = 1 << (K - 1);
   localparam int unsigned CW = $clog2(TB_DEPTH + 1);
   localparam logic [METRIC_W-1:0] PM_MAX  = '1;
   localparam logic [CW-1:0]       CNT_MAX = CW'(TB_DEPTH);
   localparam logic [K-1:0]        G0_V    = G0[K-1:0];
   localparam logic [K-1:0]        G1_V    = G1[K-1:0];

   logic [METRIC_W-1:0] pm_q [N];
   logic [METRIC_W-1:0] pm_d [N];
   logic [TB_DEPTH-1:0] sv_q [N];
   logic [TB_DEPTH-1:0] sv_d [N];
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                out_valid_q, out_valid_d;
   logic                out_bit_q, out_bit_d;

   logic [METRIC_W-1:0] pm_raw  [N];
   logic [METRIC_W-1:0] pm_norm [N];
   logic [TB_DEPTH-1:0] sv_new  [N];
   logic [METRIC_W-1:0] pm_min;
   logic [K-2:0]        best;

   function automatic logic [METRIC_W-1:0] add_sat(input logic [METRIC_W-1:0] pm,
                                                   input logic [1:0] bm);
      logic [METRIC_W:0] sum;
      sum = {1'b0, pm} + {{(METRIC_W - 1){1'b0}}, bm};
      return sum[METRIC_W] ? PM_MAX : sum[METRIC_W-1:0];
   endfunction

   function automatic logic [1:0] branch_metric(input logic [K-1:0] sr, input logic [1:0] rx);
      logic [1:0] diff;
      diff = {^(sr & G0_V), ^(sr & G1_V)} ^ rx;
      return {diff[1] & diff[0], diff[1] ^ diff[0]};
   endfunction

   // Add-compare-select, normalisation and best-state search on the incoming symbol.
   always_comb begin
      logic [K-1:0]        sr0, sr1;
      logic [METRIC_W-1:0] c0, c1;
      int unsigned         p0, p1;
      logic                found;
      sr0    = '0;
      sr1    = '0;
      c0     = '0;
      c1     = '0;
      p0     = 0;
      p1     = 0;
      found  = 1'b0;
      best   = '0;
      pm_min = PM_MAX;
      for (int unsigned ns = 0; ns < N; ns++) begin
         p0  = (ns << 1) % N;
         p1  = p0 + 1;
         // Register contents {u, predecessor}; u is the top bit of the next state.
         sr0 = K'(((ns >> (K - 2)) << (K - 1)) | p0);
         sr1 = K'(((ns >> (K - 2)) << (K - 1)) | p1);
         c0  = add_sat(pm_q[p0], branch_metric(sr0, in_bits));
         c1  = add_sat(pm_q[p1], branch_metric(sr1, in_bits));
         if (c1 < c0) begin
            pm_raw[ns] = c1;
            sv_new[ns] = {sv_q[p1][TB_DEPTH-2:0], sr1[K-1]};
         end else begin
            pm_raw[ns] = c0;
            sv_new[ns] = {sv_q[p0][TB_DEPTH-2:0], sr0[K-1]};
         end
         if (pm_raw[ns] < pm_min) pm_min = pm_raw[ns];
      end
      for (int unsigned i = 0; i < N; i++) begin
         // A saturated metric marks an unreachable path and stays pinned at max.
         pm_norm[i] = (pm_raw[i] == PM_MAX && pm_min != PM_MAX) ? PM_MAX : pm_raw[i] - pm_min;
         if (!found && pm_norm[i] == '0) begin
            best  = (K - 1)'(i);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      pm_d        = pm_q;
      sv_d        = sv_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      out_bit_d   = out_bit_q;
      if (restart) begin
         for (int unsigned i = 0; i < N; i++) begin
            pm_d[i] = (i == 0) ? '0 : PM_MAX;
            sv_d[i] = '0;
         end
         cnt_d     = '0;
         out_bit_d = 1'b0;
      end else if (in_valid) begin
         pm_d        = pm_norm;
         sv_d        = sv_new;
         cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
         out_valid_d = (cnt_d == CNT_MAX);
         out_bit_d   = sv_new[best][TB_DEPTH-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < N; i++) begin
            pm_q[i] <= (i == 0) ? '0 : PM_MAX;
            sv_q[i] <= '0;
         end
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
      end else begin
         pm_q        <= pm_d;
         sv_q        <= sv_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_bit_q   <= out_bit_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_bit   = out_bit_q;

endmodule

// File: tb/tb_viterbi_decoder_param.sv
// Self-checking bench: three decoder configurations driven by a reference encoder,
// decoded bits compared to the transmitted info stream.
module tb_viterbi_decoder_param;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       restart = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] bits_k3 = 2'b00;
   logic [1:0] bits_k5 = 2'b00;
   logic       ov_a, ob_a, ov_b, ob_b, ov_c, ob_c;

   int n_checks = 0;
   int n_fail   = 0;
   int acc      = 0;

   bit         qa[$], qb[$], qc[$];
   bit         info[$];
   bit         expb[$];
   logic [1:0] syms[$];

   typedef struct {
      logic [1:0] sym;
      logic       exp_v;
      logic       exp_b;
   } vec_t;
   vec_t tbl [11];

   always #5 clk = ~clk;

   viterbi_decoder_param #(.K(3), .G0(7), .G1(5), .TB_DEPTH(5), .METRIC_W(6)) dut_a (
      .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_bits(bits_k3),
      .out_valid(ov_a), .out_bit(ob_a));
   viterbi_decoder_param #(.K(3), .G0(7), .G1(5), .TB_DEPTH(15), .METRIC_W(6)) dut_b (
      .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_bits(bits_k3),
      .out_valid(ov_b), .out_bit(ob_b));
   viterbi_decoder_param #(.K(5), .G0('o23), .G1('o35), .TB_DEPTH(25), .METRIC_W(6)) dut_c (
      .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_bits(bits_k5),
      .out_valid(ov_c), .out_bit(ob_c));

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cycle(input logic v, input logic [1:0] b3, input logic [1:0] b5,
                        input logic rs);
      in_valid = v;
      bits_k3  = b3;
      bits_k5  = b5;
      restart  = rs;
      @(posedge clk);
      #1;
      if (rs) acc = 0;
      else if (v) acc++;
      check("valid_a", int'(ov_a), int'(v && !rs && acc >= 5));
      check("valid_b", int'(ov_b), int'(v && !rs && acc >= 15));
      check("valid_c", int'(ov_c), int'(v && !rs && acc >= 25));
      if (ov_a) qa.push_back(ob_a);
      if (ov_b) qb.push_back(ob_b);
      if (ov_c) qc.push_back(ob_c);
   endtask

   task automatic clear_q();
      qa = {};
      qb = {};
      qc = {};
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      restart  = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      check("rst_valid_a", int'(ov_a), 0);
      check("rst_bit_a", int'(ob_a), 0);
      check("rst_valid_b", int'(ov_b), 0);
      check("rst_bit_b", int'(ob_b), 0);
      check("rst_valid_c", int'(ov_c), 0);
      check("rst_bit_c", int'(ob_c), 0);
      rst = 1'b0;
      acc = 0;
      clear_q();
   endtask

   // Reference encoder: shift register {u, state}, parity against each generator.
   task automatic encode(input int k, input int g0, input int g1);
      int         st;
      int         sr;
      logic [1:0] s;
      st   = 0;
      syms = {};
      foreach (info[i]) begin
         sr   = (int'(info[i]) << (k - 1)) | st;
         s[1] = ($countones(sr & g0) % 2) == 1;
         s[0] = ($countones(sr & g1) % 2) == 1;
         syms.push_back(s);
         st = sr >> 1;
      end
      expb = info;
      repeat (64) expb.push_back(1'b0);
   endtask

   task automatic send(input bit to_k5, input int pads, input int gap_at, input int gap_len,
                       input int idle_pct);
      foreach (syms[i]) begin
         if (i == gap_at) repeat (gap_len) cycle(1'b0, 2'b00, 2'b00, 1'b0);
         if (int'($urandom_range(99)) < idle_pct) cycle(1'b0, 2'b00, 2'b00, 1'b0);
         if (to_k5) cycle(1'b1, 2'b00, syms[i], 1'b0);
         else cycle(1'b1, syms[i], 2'b00, 1'b0);
      end
      repeat (pads) cycle(1'b1, 2'b00, 2'b00, 1'b0);
   endtask

   task automatic check_bits(input string name, input int which, input int tb);
      bit got[$];
      case (which)
         0:       got = qa;
         1:       got = qb;
         default: got = qc;
      endcase
      check({name, "_count"}, got.size(), acc - tb + 1);
      for (int i = 0; i < got.size() && i < expb.size(); i++)
         check($sformatf("%s_bit%0d", name, i), int'(got[i]), int'(expb[i]));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, expected end of test");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{2'b11, 1'b0, 1'b0};
      tbl[1]  = '{2'b10, 1'b0, 1'b0};
      tbl[2]  = '{2'b00, 1'b0, 1'b0};
      tbl[3]  = '{2'b01, 1'b0, 1'b0};
      tbl[4]  = '{2'b01, 1'b1, 1'b1};
      tbl[5]  = '{2'b11, 1'b1, 1'b0};
      tbl[6]  = '{2'b00, 1'b1, 1'b1};
      tbl[7]  = '{2'b00, 1'b1, 1'b1};
      tbl[8]  = '{2'b00, 1'b1, 1'b0};
      tbl[9]  = '{2'b00, 1'b1, 1'b0};
      tbl[10] = '{2'b00, 1'b1, 1'b0};

      // Clean stream, hand-derived per-symbol expectations for the depth-5 decoder.
      do_reset();
      for (int i = 0; i < 11; i++) begin
         cycle(1'b1, tbl[i].sym, 2'b00, 1'b0);
         check($sformatf("t1_valid%0d", i), int'(ov_a), int'(tbl[i].exp_v));
         if (tbl[i].exp_v) check($sformatf("t1_bit%0d", i), int'(ob_a), int'(tbl[i].exp_b));
      end
      repeat (10) cycle(1'b1, 2'b00, 2'b00, 1'b0);
      info = '{1, 0, 1, 1, 0, 0, 0};
      encode(3, 7, 5);
      check_bits("t1_a", 0, 5);
      check_bits("t1_b", 1, 15);

      // Single channel error, corrected by the depth-15 decoder.
      do_reset();
      encode(3, 7, 5);
      syms[2] = syms[2] ^ 2'b10;
      send(1'b0, 14, -1, 0, 0);
      check_bits("t2_b", 1, 15);

      // Three-cycle in_valid gap.
      do_reset();
      encode(3, 7, 5);
      send(1'b0, 14, 3, 3, 0);
      check_bits("t3_a", 0, 5);
      check_bits("t3_b", 1, 15);

      // Restart together with in_valid mid-stream, then a fresh stream.
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, syms[i], 2'b00, 1'b0);
      clear_q();
      cycle(1'b1, 2'b11, 2'b00, 1'b1);
      info = '{1, 1, 0, 0};
      encode(3, 7, 5);
      send(1'b0, 14, -1, 0, 0);
      check_bits("t4_a", 0, 5);
      check_bits("t4_b", 1, 15);

      // Asynchronous reset between edges clears outputs at once.
      do_reset();
      info = '{1, 0, 1, 1, 0, 0, 0};
      encode(3, 7, 5);
      for (int i = 0; i < 5; i++) cycle(1'b1, syms[i], 2'b00, 1'b0);
      check("t5_pre_bit_a", int'(ob_a), 1);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("t5_async_valid_a", int'(ov_a), 0);
      check("t5_async_bit_a", int'(ob_a), 0);
      check("t5_async_valid_b", int'(ov_b), 0);
      check("t5_async_bit_b", int'(ob_b), 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      acc = 0;
      clear_q();
      info = {};
      repeat (20) info.push_back(1'b0);
      encode(3, 7, 5);
      send(1'b0, 14, -1, 0, 0);
      check_bits("t5_a", 0, 5);
      check_bits("t5_b", 1, 15);

      // K=5 random stream with zero tail and random idle cycles.
      do_reset();
      info = {};
      repeat (200) info.push_back(1'($urandom_range(1)));
      repeat (4) info.push_back(1'b0);
      encode(5, 'o23, 'o35);
      send(1'b1, 24, -1, 0, 10);
      check_bits("t6_c", 2, 25);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/viterbi_decoder_param.md
Name: viterbi_decoder_param

Overview:
Parametrised hard-decision Viterbi decoder for rate-1/2 convolutional codes. It is the successor to the fixed-mode decoder_sys block. Constraint length, generator polynomials, survivor depth and metric width are compile-time parameters, and symbol input uses a valid qualifier. It adds a synchronous restart and an output-valid strobe so it can sit directly behind the channel/demapper and ahead of the bit sink.

Parameters:
K, 3, constraint length (legal range 3..7); number of states N = 2^(K-1)
G0, 7, generator polynomial for the first code bit; bit K-1 multiplies the newest input bit
G1, 5, generator polynomial for the second code bit; same bit ordering as G0
TB_DEPTH, 15, survivor length in bits, which is also the decode latency in symbols (legal range 4..64)
METRIC_W, 6, path-metric width; metrics saturate at 2^METRIC_W-1

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
restart  in  1  synchronous re-initialisation, same effect as rst, applied at the next edge
in_valid  in  1  in_bits is accepted on this edge
in_bits  in  2  received code symbol; [1] = G0 bit, [0] = G1 bit
out_valid  out  1  out_bit holds a decoded bit this cycle
out_bit  out  1  decoded information bit, in order

Behaviour:
- Encoder model:
  - State s[K-2:0] holds the previous K-1 info bits; s[K-2] is the most recent.
  - Register sr = {u, s}.
  - c0 = ^(sr & G0), c1 = ^(sr & G1).
  - Next state = sr[K-1:1].
  - The encoder starts in state 0.
- Branch metric: Hamming distance between in_bits and the expected {c0,c1}, range 0..2.
- ACS, performed once per accepted symbol (in_valid=1 and restart=0):
  - Next state ns has predecessors p_b = {ns[K-3:0], b} for b in {0,1}; the decided input is u = ns[K-2].
  - Candidate metric = PM[p_b] + BM, saturated at max.
  - The smaller candidate wins; on a tie, b=0 wins.
  - Survivor update: SV[ns] = {SV[p_win][TB_DEPTH-2:0], u}. The newest bit is at the LSB.
- Normalisation:
  - After ACS, the minimum new metric is subtracted from every new metric before registering.
  - After any accepted symbol, at least one state therefore has PM = 0.
  - Saturated metrics stay at max (they are not reduced) until the subtraction brings them below max.
- Output selection: the best state is the lowest-indexed state with PM = 0; out_bit = SV[best][TB_DEPTH-1], the oldest bit.
- Symbol counter: counts accepted symbols and saturates at TB_DEPTH.
- out_valid timing:
  - out_valid is registered. It goes high in the cycle after an accepting edge, but only once the counter has reached TB_DEPTH including that symbol.
  - It is low on cycles with no accepted symbol (one pulse per accepted symbol).
- Latency: info bit j is emitted in the cycle after symbol j+TB_DEPTH-1 is accepted. The first TB_DEPTH-1 accepted symbols produce no output.
- in_valid gaps: all state is held, and out_valid is 0 during the gap.
- Reset and restart values:
  - PM[0] = 0; PM[other states] = max.
  - All SV = 0, counter = 0, out_valid = 0, out_bit = 0.
- restart together with in_valid: restart wins, the symbol is dropped, and out_valid = 0 on the next cycle.
- rst asserted mid-stream: outputs clear immediately, without waiting for a clock edge. Decoding restarts from encoder state 0 with the first symbol accepted after rst is released.
- No tail handling inside the block: the stream owner appends K-1 zero info bits plus TB_DEPTH-1 padding symbols to flush the final bits.

Test Plan:
- K=3, G0=7, G1=5, TB_DEPTH=5. Info 1011000, encoded 11 10 00 01 01 11 00, followed by four 00 pad symbols, in_valid held high -> out_valid is first high after the 5th symbol. Bits emitted in order are 1,0,1,1,0,0,0.
- Same stream with TB_DEPTH=15 and 14 pad symbols, with symbol 2 corrupted from 00 to 10 -> the decoded bits are still 1011000, i.e. the single error is corrected.
- Same stream with in_valid deasserted for 3 cycles between symbols 3 and 4 -> the output bit sequence is unchanged. out_valid is 0 during the gap, and the number of out_valid pulses equals the number of accepted symbols minus 4.
- restart pulsed together with in_valid mid-stream, then a new encoded stream for info 1100 is sent -> the dropped symbol has no effect. The new stream decodes as 1,1,0,0 with a fresh latency of TB_DEPTH-1 symbols.
- rst asserted asynchronously between edges mid-stream -> out_valid and out_bit go to 0 immediately. After release, the all-zero stream decodes to all zeros with the first out_valid after symbol TB_DEPTH.
- K=5, G0=23, G1=35 (octal), TB_DEPTH=25. A 200-bit random info stream from a bench reference encoder with zero tail, with no channel errors -> the decoded bits exactly match the input. PM of the best state stays 0 throughout.
